// File: rtl/kpn_queue_arbiter.sv
// Two-producer, one-consumer word queue with a fair alternating-priority write arbiter.
// Grants are combinational; read data, pointers, occupancy and arbiter state are registered.
module kpn_queue_arbiter #(
    parameter int BITS_NUMBER   = 16,
    parameter int FIFO_ELEMENTS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_a,
    input  logic [BITS_NUMBER-1:0]   data_a,
    output logic                     grant_a,
    input  logic                     req_b,
    input  logic [BITS_NUMBER-1:0]   data_b,
    output logic                     grant_b,
    input  logic                     rd,
    output logic [BITS_NUMBER-1:0]   output_1,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [FIFO_ELEMENTS:0]   count
);

    localparam int DEPTH = 2 ** FIFO_ELEMENTS;
    localparam logic [FIFO_ELEMENTS:0]   FULL_CNT = (FIFO_ELEMENTS + 1)'(DEPTH);
    localparam logic [FIFO_ELEMENTS:0]   CNT_ONE  = (FIFO_ELEMENTS + 1)'(1);
    localparam logic [FIFO_ELEMENTS-1:0] PTR_ONE  = FIFO_ELEMENTS'(1);

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    prio_t                    state_q, state_d;
    logic [FIFO_ELEMENTS-1:0] w_ptr_q, w_ptr_d;
    logic [FIFO_ELEMENTS-1:0] r_ptr_q, r_ptr_d;
    logic [FIFO_ELEMENTS:0]   count_q, count_d;
    logic [BITS_NUMBER-1:0]   out_q, out_d;
    logic                     rd_valid_q, rd_valid_d;

    logic [BITS_NUMBER-1:0]   mem [DEPTH];
    logic                     wr_en;
    logic                     rd_en;
    logic [BITS_NUMBER-1:0]   wr_data;

    // Occupancy counter is the single source of truth, so a wrapped w_ptr == r_ptr is never ambiguous.
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign output_1 = out_q;
    assign rd_valid = rd_valid_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_d    = state_q;
        w_ptr_d    = w_ptr_q;
        r_ptr_d    = r_ptr_q;
        count_d    = count_q;
        out_d      = out_q;
        rd_valid_d = 1'b0;

        if (!reset && !full) begin
            if (req_a && (!req_b || state_q == PRIO_A)) begin
                grant_a = 1'b1;
            end else if (req_b) begin
                grant_b = 1'b1;
            end
        end

        wr_en   = grant_a | grant_b;
        wr_data = grant_a ? data_a : data_b;
        // Read qualifies on the registered count only: a same-cycle write is never bypassed.
        rd_en   = rd && !empty;

        if (grant_a) begin
            state_d = PRIO_B;
        end else if (grant_b) begin
            state_d = PRIO_A;
        end

        if (wr_en) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end

        if (rd_en) begin
            r_ptr_d    = r_ptr_q + PTR_ONE;
            out_d      = mem[r_ptr_q];
            rd_valid_d = 1'b1;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (reset) begin
            state_q    <= PRIO_A;
            w_ptr_q    <= '0;
            r_ptr_q    <= '0;
            count_q    <= '0;
            out_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_ptr_q    <= w_ptr_d;
            r_ptr_q    <= r_ptr_d;
            count_q    <= count_d;
            out_q      <= out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // NOTE: storage is deliberately not reset; clearing count/pointers already makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_kpn_queue_arbiter.sv
// Self-checking bench for kpn_queue_arbiter: a reference queue model acts as the scoreboard
// for expected grants, read data, occupancy and flags.
module tb_kpn_queue_arbiter;

    localparam int W     = 16;
    localparam int FE    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_a, req_b, rd;
    logic [W-1:0]  data_a, data_b;
    logic          grant_a, grant_b;
    logic [W-1:0]  output_1;
    logic          rd_valid, empty, full;
    logic [FE:0]   count;

    kpn_queue_arbiter #(.BITS_NUMBER(W), .FIFO_ELEMENTS(FE)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_a    (req_a),
        .data_a   (data_a),
        .grant_a  (grant_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .grant_b  (grant_b),
        .rd       (rd),
        .output_1 (output_1),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Scoreboard: words pushed when the model grants a write, popped when a read is expected.
    logic [W-1:0] sb[$];
    logic         m_prio_b = 1'b0;
    logic [W-1:0] m_out    = '0;
    logic         m_valid  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, check grants before the rising edge,
    // then advance the model and check registered outputs just after the rising edge.
    task automatic cycle(input logic rst, input logic ra, input logic [W-1:0] da,
                         input logic rb, input logic [W-1:0] db, input logic r,
                         output logic ga, output logic gb);
        logic exp_rd;
        logic m_full;
        @(negedge clk);
        reset  = rst;
        req_a  = ra;
        data_a = da;
        req_b  = rb;
        data_b = db;
        rd     = r;
        #1;
        m_full = (sb.size() == DEPTH);
        ga     = !rst && !m_full && ra && (!rb || !m_prio_b);
        gb     = !rst && !m_full && rb && (!ra || m_prio_b);
        exp_rd = !rst && r && (sb.size() != 0);
        check("grant_a", 32'(grant_a), 32'(ga));
        check("grant_b", 32'(grant_b), 32'(gb));
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_prio_b = 1'b0;
            m_out    = '0;
            m_valid  = 1'b0;
        end else begin
            m_valid = exp_rd;
            if (exp_rd) m_out = sb.pop_front();
            if (ga) begin
                sb.push_back(da);
                m_prio_b = 1'b1;
            end
            if (gb) begin
                sb.push_back(db);
                m_prio_b = 1'b0;
            end
        end
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("output_1", 32'(output_1), 32'(m_out));
        check("count",    32'(count),    32'(sb.size()));
        check("empty",    32'(empty),    32'(sb.size() == 0));
        check("full",     32'(full),     32'(sb.size() == DEPTH));
    endtask

    initial begin
        logic         ga, gb;
        logic         pa, pb;
        logic [W-1:0] da_c, db_c;
        int           nw;

        reset  = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        rd     = 1'b0;
        data_a = '0;
        data_b = '0;

        // Reset, including requests and a read held during reset.
        cycle(1'b1, 1'b0, 16'h0,    1'b0, 16'h0, 1'b0, ga, gb);
        cycle(1'b1, 1'b1, 16'h1234, 1'b1, 16'h5678, 1'b1, ga, gb);

        // Single write then read.
        cycle(1'b0, 1'b1, 16'h0011, 1'b0, 16'h0, 1'b0, ga, gb);
        check("s1_count", 32'(count), 32'd1);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, ga, gb);
        check("s1_data", 32'(output_1), 32'h0011);

        // Tie alternation from PRIO_A, then drain.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, ga, gb);
        da_c = 16'hA000;
        db_c = 16'hB000;
        for (int n = 0; n < 4; n++) begin
            cycle(1'b0, 1'b1, da_c, 1'b1, db_c, 1'b0, ga, gb);
            if (ga) da_c++;
            if (gb) db_c++;
        end
        for (int n = 0; n < 4; n++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, ga, gb);
        end
        check("s2_last", 32'(output_1), 32'hB001);

        // Fill to full, then a write attempt while full.
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, ga, gb);
        for (int n = 0; n < DEPTH; n++) begin
            cycle(1'b0, 1'b1, W'(n), 1'b0, 16'h0, 1'b0, ga, gb);
        end
        check("s3_full", 32'(full), 32'd1);
        cycle(1'b0, 1'b1, 16'h00AA, 1'b0, 16'h0, 1'b0, ga, gb);

        // Full with read and write together: blocked first, accepted next.
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b1, ga, gb);
        check("s4_count", 32'(count), 32'd31);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b1, ga, gb);
        for (int n = 0; n < DEPTH + 2 && sb.size() != 0; n++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, ga, gb);
        end
        check("s4_drained", 32'(empty), 32'd1);

        // Read of empty queue with same-cycle write: no bypass.
        cycle(1'b0, 1'b1, 16'h00FF, 1'b0, 16'h0, 1'b1, ga, gb);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, ga, gb);
        check("s5_data", 32'(output_1), 32'h00FF);

        // 40 writes from both producers interleaved with random reads, through pointer wrap.
        pa   = 1'b0;
        pb   = 1'b0;
        da_c = 16'h2000;
        db_c = 16'h3000;
        nw   = 0;
        for (int n = 0; n < 400 && (nw < 40 || pa || pb); n++) begin
            if (!pa && nw + int'(pb) < 40) pa = 1'($urandom_range(0, 1));
            if (!pb && nw + int'(pa) < 40) pb = 1'($urandom_range(0, 1));
            cycle(1'b0, pa, da_c, pb, db_c, 1'($urandom_range(0, 1)), ga, gb);
            if (ga) begin
                pa = 1'b0;
                da_c++;
                nw++;
            end
            if (gb) begin
                pb = 1'b0;
                db_c++;
                nw++;
            end
        end
        check("s6_writes", 32'(nw), 32'd40);
        for (int n = 0; n < DEPTH + 2 && sb.size() != 0; n++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, ga, gb);
        end
        check("s6_drained", 32'(empty), 32'd1);

        // Reset mid-operation with five words queued, overlapping a read and a write.
        for (int n = 0; n < 5; n++) begin
            cycle(1'b0, 1'b0, 16'h0, 1'b1, W'(16'h4000 + n), 1'b0, ga, gb);
        end
        check("s7_count", 32'(count), 32'd5);
        cycle(1'b1, 1'b1, 16'h7777, 1'b0, 16'h0, 1'b1, ga, gb);
        check("s7_rst_count", 32'(count), 32'd0);
        check("s7_rst_valid", 32'(rd_valid), 32'd0);
        cycle(1'b0, 1'b1, 16'h5A5A, 1'b1, 16'hA5A5, 1'b0, ga, gb);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, ga, gb);
        check("s7_prio_a", 32'(output_1), 32'h5A5A);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
